// File: rtl/memory_responder.sv
// Word-addressed single-port memory behind a Read/Write level handshake.
// Each access takes WAIT_STATES extra cycles; Done holds until the request drops.
module memory_responder #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Done,
    output logic                  Busy,
    output logic                  Error
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [2:0] WaitLoad = 3'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StComplete} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    op_write_q;
    logic                    accept;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   commit_addr;
    logic [DATA_WIDTH-1:0]   commit_data;
    logic                    commit_write;

    logic [DATA_WIDTH-1:0]   mem [Depth];

    assign accept = (state_q == StIdle) && (Read ^ Write);
    assign Error  = (state_q == StIdle) && Read && Write;

    // With zero wait states the commit happens on the accepting edge, before
    // the latches are loaded, so the live inputs are used in IDLE.
    assign commit_addr  = (state_q == StIdle) ? Address : addr_q;
    assign commit_data  = (state_q == StIdle) ? Data_in : wdata_q;
    assign commit_write = (state_q == StIdle) ? Write   : op_write_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    count_d = WaitLoad;
                    if (WAIT_STATES == 0) begin
                        state_d = StComplete;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (count_q <= 3'd1) begin
                    state_d = StComplete;
                    count_d = 3'd0;
                    commit  = 1'b1;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
            StComplete: begin
                if (!Read && !Write) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            count_q    <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            Data_out   <= '0;
            Done       <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            Done    <= (state_d == StComplete);
            Busy    <= (state_d != StIdle);
            if (accept) begin
                addr_q     <= Address;
                wdata_q    <= Data_in;
                op_write_q <= Write;
            end
            if (commit && !commit_write) begin
                Data_out <= mem[commit_addr];
            end
        end
    end

    // Storage has no reset so it can map onto a RAM macro.
    always_ff @(posedge Clock) begin
        if (commit && commit_write) begin
            mem[commit_addr] <= commit_data;
        end
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, SHALL set word address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set word width.
REQ-003 Parameter WAIT_STATES, default 2, range 0..7, SHALL set extra access cycles.
REQ-004 Clock  in  1  SHALL be the single clock; all state changes on rising edge.
REQ-005 Reset_n  in  1  SHALL be asynchronous, active-low reset.
REQ-006 Read  in  1  SHALL be the level read request from the control unit.
REQ-007 Write  in  1  SHALL be the level write request from the control unit.
REQ-008 Address  in  ADDR_WIDTH  SHALL be the word address (MAR low bits).
REQ-009 Data_in  in  DATA_WIDTH  SHALL be the write data (MDR contents).
REQ-010 Data_out  out  DATA_WIDTH  SHALL be the registered read data (to MDR Mdatain).
REQ-011 Done  out  1  SHALL indicate the access is complete.
REQ-012 Busy  out  1  SHALL be high whenever state is not IDLE.
REQ-013 Error  out  1  SHALL flag a conflicting request (Read and Write both high).

Function
REQ-014 Storage SHALL be 2^ADDR_WIDTH words of DATA_WIDTH bits, single port, not cleared by reset.
REQ-015 FSM SHALL have states IDLE, WAIT, COMPLETE; 4-phase handshake.
REQ-016 IDLE: exactly one of Read/Write high at an edge SHALL latch Address, Data_in and operation, load wait counter with WAIT_STATES, go to WAIT (WAIT_STATES>0) or COMPLETE (WAIT_STATES=0).
REQ-017 WAIT: counter SHALL decrement each edge; at 1 go to COMPLETE.
REQ-018 Access SHALL commit on the edge entering COMPLETE: write stores latched data at latched address; read loads Data_out from latched address.
REQ-019 Done SHALL be high throughout COMPLETE; first Done cycle is WAIT_STATES+1 cycles after the sampling edge.
REQ-020 COMPLETE SHALL persist while Read or Write is high and return to IDLE at the first edge with both low.
REQ-021 Data_out SHALL hold its value until the next read commit; writes SHALL NOT alter Data_out.
REQ-022 Address, Data_in, Read/Write changes during WAIT SHALL be ignored; latched values used.
REQ-023 Request dropped during WAIT SHALL NOT abort; access commits, COMPLETE lasts one cycle.
REQ-024 Read and Write both high in IDLE SHALL assert Error (combinational) for that cycle, perform no access, remain IDLE.
REQ-025 Error SHALL be low in WAIT and COMPLETE regardless of inputs.
REQ-026 Read-after-write to the same address SHALL return the newly written data.

Reset
REQ-027 Reset_n low SHALL force IDLE, counter 0, Data_out 0, Done 0, Busy 0, latches 0, immediately.
REQ-028 Reset during WAIT SHALL abort the access; no write commits, memory unchanged.
REQ-029 After Reset_n rises, a request already high SHALL be accepted at the first rising edge.

Verification
REQ-030 WAIT_STATES=2: Write addr 0x005 data 0xDEADBEEF held -> Done high at cycle 3 after sampling edge; Busy high cycles 1..3+; drop Write -> IDLE next edge.
REQ-031 Then Read addr 0x005 -> Data_out=0xDEADBEEF with Done at cycle 3; Data_out stays 0xDEADBEEF after Read drops.
REQ-032 Read and Write both high in IDLE for 3 cycles -> Error high 3 cycles, Busy 0, Done 0, addr 0x005 still reads 0xDEADBEEF.
REQ-033 Write addr 0x1FF data 0x12345678, Reset_n pulsed low in WAIT -> all outputs 0 at once; later read of 0x1FF returns prior contents, not 0x12345678.
REQ-034 WAIT_STATES=0: Read addr 0x000 after write 0x0000000A -> Done first cycle after sampling edge, Data_out=0x0000000A.
REQ-035 Read addr 0x010 then Address changed to 0x020 during WAIT -> Data_out equals word at 0x010.
